i2c_reg_target: RTL and testbench



---
 rtl/i2c_reg_target_if.sv | 25 ++
 rtl/i2c_reg_target.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_target_if.sv
// Register-side port bundle of the I2C target: address select, write strobe
// port, read fetch port and bus-activity flag.
interface i2c_reg_target_if #(
  parameter int PTR_W = 8
);
  logic [6:0]       addr_in;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [PTR_W-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic             busy;

  // master: the I2C target, which issues register accesses
  modport master (
    input  addr_in, rd_data,
    output wr_en, wr_addr, wr_data, rd_addr, busy
  );

  // slave: the register file / bench that answers them
  modport slave (
    output addr_in, rd_data,
    input  wr_en, wr_addr, wr_data, rd_addr, busy
  );
endinterface

// File: rtl/i2c_reg_target.sv
// Oversampled I2C register target: START/STOP decode, 7-bit address match,
// pointer-based register writes and auto-incrementing reads.
module i2c_reg_target #(
  parameter int PTR_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire              i2c_sda,
  inout  wire              i2c_scl,
  i2c_reg_target_if.master reg_if
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_prev, r_sda_prev;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic [PTR_W-1:0]       r_ptr, w_ptr_nxt;
  logic                   r_sda_oe, w_sda_oe_nxt;
  logic                   r_ack_phase, w_ack_phase_nxt;
  logic                   r_rw, w_rw_nxt;
  logic                   r_rd_load, w_rd_load_nxt;
  logic                   r_wr_en, w_wr_en_nxt;
  logic [PTR_W-1:0]       r_wr_addr, w_wr_addr_nxt;
  logic [7:0]             r_wr_data, w_wr_data_nxt;
  logic                   r_busy, w_busy_nxt;

  logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  assign i2c_sda = r_sda_oe ? 1'b0 : 1'bz;

  assign reg_if.wr_en   = r_wr_en;
  assign reg_if.wr_addr = r_wr_addr;
  assign reg_if.wr_data = r_wr_data;
  assign reg_if.rd_addr = r_ptr;
  assign reg_if.busy    = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_ptr_nxt       = r_ptr;
    w_sda_oe_nxt    = r_sda_oe;
    w_ack_phase_nxt = r_ack_phase;
    w_rw_nxt        = r_rw;
    w_rd_load_nxt   = 1'b0;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_busy_nxt      = r_busy;

    if (w_start) begin
      w_state_nxt     = S_ADDR;
      w_cnt_nxt       = 4'd0;
      w_sda_oe_nxt    = 1'b0;
      w_ack_phase_nxt = 1'b0;
      w_busy_nxt      = 1'b1;
    end else if (w_stop) begin
      w_state_nxt     = S_IDLE;
      w_cnt_nxt       = 4'd0;
      w_sda_oe_nxt    = 1'b0;
      w_ack_phase_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt = 4'd0;
              if (r_state == S_ADDR) begin
                if (r_shift[6:0] == reg_if.addr_in) begin
                  w_state_nxt = S_ADDR_ACK;
                  w_rw_nxt    = w_sda;
                end else begin
                  w_state_nxt = S_WAIT_STOP;
                end
              end else if (r_state == S_PTR) begin
                w_ptr_nxt   = PTR_W'(w_byte);
                w_state_nxt = S_PTR_ACK;
              end else begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_ptr;
                w_wr_data_nxt = w_byte;
                w_state_nxt   = S_WDATA_ACK;
              end
            end
          end
        end
        // ACK spans from the fall ending bit 8 to the fall ending bit 9
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_phase) begin
              w_sda_oe_nxt    = 1'b1;
              w_ack_phase_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt    = 1'b0;
              w_ack_phase_nxt = 1'b0;
              w_cnt_nxt       = 4'd0;
              if (r_state == S_WDATA_ACK) begin
                w_ptr_nxt   = r_ptr + 1'b1;
                w_state_nxt = S_WDATA;
              end else if (r_state == S_PTR_ACK) begin
                w_state_nxt = S_WDATA;
              end else if (r_rw) begin
                w_state_nxt   = S_RDATA;
                w_rd_load_nxt = 1'b1;
              end else begin
                w_state_nxt = S_PTR;
              end
            end
          end
        end
        S_RDATA: begin
          if (r_rd_load) begin
            w_shift_nxt  = reg_if.rd_data;
            w_sda_oe_nxt = ~reg_if.rd_data[7];
            w_cnt_nxt    = 4'd0;
          end else if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_RDATA_ACK;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_state_nxt = S_WAIT_STOP;
            end else begin
              w_ptr_nxt = r_ptr + 1'b1;
            end
          end else if (w_scl_fall) begin
            w_state_nxt   = S_RDATA;
            w_rd_load_nxt = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= 8'd0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_ack_phase <= 1'b0;
      r_rw        <= 1'b0;
      r_rd_load   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_ack_phase <= w_ack_phase_nxt;
      r_rw        <= w_rw_nxt;
      r_rd_load   <= w_rd_load_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged open-drain master, register memory
// model and a transaction-level pointer/write-log reference.
module tb_i2c_reg_target;
  localparam int Q = 60;

  logic clk = 1'b0;
  logic rst;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;
  wire  sda_bus;
  wire  scl_bus;

  always #5 clk = ~clk;

  pullup (sda_bus);
  pullup (scl_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;
  assign scl_bus = m_scl ? 1'bz : 1'b0;

  i2c_reg_target_if #(.PTR_W(8)) reg_if ();

  i2c_reg_target #(.PTR_W(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .i2c_sda (sda_bus),
    .i2c_scl (scl_bus),
    .reg_if  (reg_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          tgt_low  = 0;
  logic [7:0]  mem [256];
  logic [7:0]  tx_data [4];
  logic [7:0]  model_ptr;
  logic [15:0] wr_q [$];
  logic [15:0] exp_wr_q [$];

  // register file answers one cycle after the address changes
  always @(posedge clk) reg_if.rd_data <= mem[reg_if.rd_addr];

  always @(negedge clk) begin
    if (reg_if.wr_en === 1'b1) wr_q.push_back({reg_if.wr_addr, reg_if.wr_data});
    if (m_sda === 1'b1 && sda_bus === 1'b0) tgt_low = tgt_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda = b;
    #Q m_scl = 1'b1;
    #Q r = sda_bus;
    #Q m_scl = 1'b0;
    #Q;
  endtask

  task automatic m_start();
    m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
    #Q;
  endtask

  task automatic m_stop();
    m_sda = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask

  task automatic m_write_byte(input logic [7:0] b, output logic ack_n);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, ack_n);
  endtask

  task automatic m_read_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      b[i] = r;
    end
    m_bit(nack, r);
  endtask

  task automatic check_writes();
    logic [15:0] got, exp;
    chk("wr_count", wr_q.size(), exp_wr_q.size());
    while (wr_q.size() > 0 && exp_wr_q.size() > 0) begin
      got = wr_q.pop_front();
      exp = exp_wr_q.pop_front();
      chk("wr_addr", got[15:8], exp[15:8]);
      chk("wr_data", got[7:0], exp[7:0]);
    end
    wr_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic do_write(input logic [6:0] a7, input logic [7:0] ptr, input int n);
    logic an;
    logic hit;
    hit = (a7 == reg_if.addr_in);
    m_start();
    chk("busy_start", reg_if.busy, 1'b1);
    m_write_byte({a7, 1'b0}, an);
    chk("addr_ack", an, !hit);
    m_write_byte(ptr, an);
    chk("ptr_ack", an, !hit);
    if (hit) model_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      m_write_byte(tx_data[i], an);
      chk("data_ack", an, !hit);
      if (hit) begin
        exp_wr_q.push_back({model_ptr, tx_data[i]});
        model_ptr = model_ptr + 8'd1;
      end
    end
    if (!hit) chk("busy_wait_stop", reg_if.busy, 1'b1);
    m_stop();
    chk("busy_stop", reg_if.busy, 1'b0);
    chk("rd_addr_wr", reg_if.rd_addr, model_ptr);
    check_writes();
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n);
    logic       an;
    logic [7:0] b;
    m_start();
    if (set_ptr) begin
      m_write_byte({reg_if.addr_in, 1'b0}, an);
      chk("raddr_w_ack", an, 1'b0);
      m_write_byte(ptr, an);
      chk("rptr_ack", an, 1'b0);
      model_ptr = ptr;
      m_start();
    end
    m_write_byte({reg_if.addr_in, 1'b1}, an);
    chk("raddr_r_ack", an, 1'b0);
    for (int i = 0; i < n; i++) begin
      m_read_byte(i == n - 1, b);
      chk("rd_byte", b, mem[model_ptr]);
      if (i != n - 1) model_ptr = model_ptr + 8'd1;
    end
    chk("sda_rel_nack", sda_bus, 1'b1);
    m_stop();
    chk("busy_stop_rd", reg_if.busy, 1'b0);
    chk("rd_addr_rd", reg_if.rd_addr, model_ptr);
    check_writes();
  endtask

  initial begin
    logic       r;
    logic       an;
    logic [7:0] b;
    logic [7:0] p;
    logic [6:0] flip;
    int         kind, n;

    rst = 1'b1;
    reg_if.addr_in = 7'h2A;
    model_ptr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    #43;
    chk("rst_busy", reg_if.busy, 1'b0);
    chk("rst_wr_en", reg_if.wr_en, 1'b0);
    chk("rst_rd_addr", reg_if.rd_addr, 8'h00);
    chk("rst_sda", sda_bus, 1'b1);
    rst = 1'b0;
    #20;

    tx_data[0] = 8'hA5; tx_data[1] = 8'h3C;
    do_write(7'h2A, 8'h05, 2);

    tgt_low = 0;
    tx_data[0] = 8'h99;
    do_write(7'h2B, 8'h00, 1);
    chk("mismatch_no_drive", tgt_low, 0);

    do_read(1'b1, 8'h10, 2);
    chk("rd_ptr_0x11", reg_if.rd_addr, 8'h11);

    tx_data[0] = 8'h11; tx_data[1] = 8'h22;
    do_write(7'h2A, 8'hFF, 2);

    // STOP after four data bits discards the byte
    m_start();
    m_write_byte({7'h2A, 1'b0}, an);
    chk("mid_addr_ack", an, 1'b0);
    m_write_byte(8'h40, an);
    chk("mid_ptr_ack", an, 1'b0);
    model_ptr = 8'h40;
    for (int i = 0; i < 4; i++) m_bit(i[0], r);
    m_stop();
    chk("mid_busy", reg_if.busy, 1'b0);
    check_writes();
    tx_data[0] = 8'h77;
    do_write(7'h2A, 8'h41, 1);

    // general call only answered when the target address is zero
    do_write(7'h00, 8'h20, 1);
    reg_if.addr_in = 7'h00;
    tx_data[0] = 8'h5A;
    do_write(7'h00, 8'h20, 1);
    reg_if.addr_in = 7'h2A;

    // reset while the target holds the address ACK low
    m_start();
    for (int i = 6; i >= 0; i--) begin
      b = {1'b0, 7'h2A};
      m_bit(b[i], r);
    end
    m_bit(1'b0, r);
    m_sda = 1'b1;
    #Q;
    chk("ack_low_before_rst", sda_bus, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_sda_release", sda_bus, 1'b1);
    chk("rst_busy_mid", reg_if.busy, 1'b0);
    chk("rst_wr_en_mid", reg_if.wr_en, 1'b0);
    chk("rst_wr_addr_mid", reg_if.wr_addr, 8'h00);
    chk("rst_wr_data_mid", reg_if.wr_data, 8'h00);
    chk("rst_rd_addr_mid", reg_if.rd_addr, 8'h00);
    #29;
    rst = 1'b0;
    model_ptr = 8'h00;
    #20 m_scl = 1'b1;
    #Q;
    do_read(1'b0, 8'h00, 1);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 14; t++) begin
      reg_if.addr_in = 7'($urandom_range(1, 127));
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) tx_data[i] = 8'($urandom);
      p = 8'($urandom);
      if ($urandom_range(0, 3) == 0) p = 8'hFF;
      flip = 7'h01 << $urandom_range(0, 6);
      case (kind)
        0, 1: do_write(reg_if.addr_in, p, n);
        2: do_read(1'($urandom_range(0, 1)), p, n);
        default: do_write(reg_if.addr_in ^ flip, p, n);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
